medidor_agua: RTL and testbench

Ultrasonic water-level measurement responder for the coffee-machine datapath. It answers the control unit's measure request: it fires an HC-SR04-style trigger pulse, times the echo, converts the pulse to centimetres and compares the result against a threshold. It then returns a ready flag and a sufficient-water verdict. It is the sensor-side end of the `medir_agua` / `pronto_sensor_agua` / `suficiente` handshake.

---
 rtl/cafeteira_pkg.sv | 18 +
 rtl/medidor_agua_if.sv | 25 ++
 rtl/medidor_agua_contador.sv | 29 ++
 rtl/medidor_agua.sv | 156 +++++++++++++++
 tb/tb_medidor_agua.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cafeteira_pkg.sv
// Shared definitions for the coffee-machine datapath: state encodings of the
// water-level responder and the distance width.
package cafeteira_pkg;

    localparam int DIST_W = 9;
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        GERA_TRIGGER = 4'd1,
        ESPERA_ECHO  = 4'd2,
        MEDE_ECHO    = 4'd3,
        CALCULA      = 4'd4,
        FINAL        = 4'd5,
        INTERVALO    = 4'd6
    } estado_medidor_t;

endpackage

// File: rtl/medidor_agua_if.sv
// Bundle between the control unit / ultrasonic sensor (master) and the
// water-level responder (slave).
interface medidor_agua_if;
    import cafeteira_pkg::*;

    logic              medir;
    logic              zera;
    logic              echo;
    logic              trigger;
    logic              pronto;
    logic              suficiente;
    logic [DIST_W-1:0] distancia;
    logic [3:0]        db_estado;

    modport master (
        output medir, zera, echo,
        input  trigger, pronto, suficiente, distancia, db_estado
    );

    modport slave (
        input  medir, zera, echo,
        output trigger, pronto, suficiente, distancia, db_estado
    );

endinterface

// File: rtl/medidor_agua_contador.sv
// contador_m: modulo-M counter with synchronous clear and enable; fim is high
// while the count sits at M-1.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (zera)
            r_q <= '0;
        else if (conta)
            r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
    end

    assign fim = (r_q == LAST);

endmodule

// File: rtl/medidor_agua.sv
// medidor_agua: HC-SR04 style water-level responder (trigger, echo timing,
// cm conversion, threshold). Define MEDIDOR_AGUA_MEDIA_EN to average 4 readings.
module medidor_agua
    import cafeteira_pkg::*;
#(
    parameter int TRIGGER_CYCLES   = 500,
    parameter int CYCLES_PER_CM    = 2941,
    parameter int LIMIAR_CM        = 10,
    parameter int TIMEOUT_CYCLES   = 1_500_000,
    parameter int INTERVALO_CYCLES = 3_000_000
) (
    input  logic           clock,
    input  logic           reset,
    medidor_agua_if.slave  bus
);

    localparam logic [DIST_W-1:0] LIMIAR = DIST_W'(LIMIAR_CM);

    estado_medidor_t   r_estado, w_proximo;
    logic              r_echoMeta, r_echoSync;
    logic [DIST_W-1:0] r_cm, r_distancia, w_resultado;
    logic              r_suficiente;
    logic              w_fimTrigger, w_fimTick, w_fimTimeout, w_fimIntervalo;
    logic              w_esperando, w_contaEcho, w_ultima;

    assign w_esperando = (r_estado == ESPERA_ECHO) || (r_estado == MEDE_ECHO);
    // The first synchronized-high cycle is still spent in espera_echo, so it counts too.
    assign w_contaEcho = w_esperando && r_echoSync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_echoMeta <= 1'b0;
            r_echoSync <= 1'b0;
        end else begin
            r_echoMeta <= bus.echo;
            r_echoSync <= r_echoMeta;
        end
    end

    contador_m #(.M(TRIGGER_CYCLES)) u_trigger (
        .clock(clock), .reset(reset),
        .zera(bus.zera || (r_estado != GERA_TRIGGER)),
        .conta(r_estado == GERA_TRIGGER), .fim(w_fimTrigger)
    );

    contador_m #(.M(CYCLES_PER_CM)) u_tick (
        .clock(clock), .reset(reset),
        .zera(bus.zera || !w_esperando),
        .conta(w_contaEcho), .fim(w_fimTick)
    );

    contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
        .clock(clock), .reset(reset),
        .zera(bus.zera || !w_esperando),
        .conta(w_esperando), .fim(w_fimTimeout)
    );

    contador_m #(.M(INTERVALO_CYCLES)) u_intervalo (
        .clock(clock), .reset(reset),
        .zera(bus.zera || (r_estado != INTERVALO)),
        .conta(r_estado == INTERVALO), .fim(w_fimIntervalo)
    );

`ifdef MEDIDOR_AGUA_MEDIA_EN
    logic [1:0]        r_leitura;
    logic [DIST_W+1:0] r_soma, w_somaTotal;

    assign w_somaTotal = r_soma + {2'b00, r_cm};
    assign w_ultima    = (r_leitura == 2'd3);
    assign w_resultado = w_somaTotal[DIST_W+1:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leitura <= '0;
            r_soma    <= '0;
        end else if (bus.zera || (r_estado == INICIAL) || (r_estado == FINAL)) begin
            r_leitura <= '0;
            r_soma    <= '0;
        end else if ((r_estado == CALCULA) && !w_ultima) begin
            r_leitura <= r_leitura + 1'b1;
            r_soma    <= w_somaTotal;
        end
    end
`else
    assign w_ultima    = 1'b1;
    assign w_resultado = r_cm;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_estado <= INICIAL;
        else
            r_estado <= w_proximo;
    end

    always_comb begin
        w_proximo = r_estado;
        if (bus.zera) begin
            w_proximo = INICIAL;
        end else begin
            case (r_estado)
                INICIAL:      if (bus.medir) w_proximo = GERA_TRIGGER;
                GERA_TRIGGER: if (w_fimTrigger) w_proximo = ESPERA_ECHO;
                ESPERA_ECHO: begin
                    if (w_fimTimeout)    w_proximo = INICIAL;
                    else if (r_echoSync) w_proximo = MEDE_ECHO;
                end
                MEDE_ECHO: begin
                    if (w_fimTimeout)     w_proximo = INICIAL;
                    else if (!r_echoSync) w_proximo = CALCULA;
                end
                CALCULA:      w_proximo = w_ultima ? FINAL : INTERVALO;
                FINAL:        if (bus.medir) w_proximo = GERA_TRIGGER;
                INTERVALO:    if (w_fimIntervalo) w_proximo = GERA_TRIGGER;
                default:      w_proximo = INICIAL;
            endcase
        end
    end

    always_comb begin
        bus.trigger   = 1'b0;
        bus.pronto    = 1'b0;
        bus.db_estado = r_estado;
        case (r_estado)
            GERA_TRIGGER: bus.trigger = 1'b1;
            FINAL:        bus.pronto  = 1'b1;
            default:      ;
        endcase
    end

    // Distance results survive a timeout; only calcula, zera or reset change them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cm         <= '0;
            r_distancia  <= '0;
            r_suficiente <= 1'b0;
        end else if (bus.zera) begin
            r_cm         <= '0;
            r_distancia  <= '0;
            r_suficiente <= 1'b0;
        end else begin
            if (r_estado == GERA_TRIGGER)
                r_cm <= '0;
            else if (w_contaEcho && w_fimTick && (r_cm != DIST_MAX))
                r_cm <= r_cm + 1'b1;
            if ((r_estado == CALCULA) && w_ultima) begin
                r_distancia  <= w_resultado;
                r_suficiente <= (w_resultado <= LIMIAR);
            end
        end
    end

    assign bus.distancia  = r_distancia;
    assign bus.suficiente = r_suficiente;

endmodule

// File: tb/tb_medidor_agua.sv
// Self-checking bench for medidor_agua: directed and random echo widths compared
// against an arithmetic model of the distance/threshold rules.
module tb_medidor_agua;

    localparam int TRIG   = 5;
    localparam int CPC    = 10;
    localparam int LIMIAR = 10;
    localparam int TMO    = 2000;
    localparam int INTERV = 20;
`ifdef MEDIDOR_AGUA_MEDIA_EN
    localparam int N_LEIT = 4;
`else
    localparam int N_LEIT = 1;
`endif
    // Raw low sampled, second sync stage, calcula, final.
    localparam int PRONTO_LAT = 4;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   lat;
    int   cnt;
    int   expDist;

    medidor_agua_if bus();

    medidor_agua #(
        .TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .LIMIAR_CM(LIMIAR),
        .TIMEOUT_CYCLES(TMO), .INTERVALO_CYCLES(INTERV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int cmOf(input int n);
        return (n / CPC > 511) ? 511 : n / CPC;
    endfunction

    function automatic int modelDist(input int e0, input int e1, input int e2, input int e3);
        if (N_LEIT == 4)
            return (cmOf(e0) + cmOf(e1) + cmOf(e2) + cmOf(e3)) / 4;
        return cmOf(e0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseMedir();
        bus.medir = 1'b1;
        step();
        bus.medir = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] s, input string tag);
        int k;
        k = 0;
        while (bus.db_estado !== s && k < 3000) begin
            step();
            k++;
        end
        checkOutput(tag, bus.db_estado, s);
    endtask

    task automatic applyStimulus(input int n);
        bus.echo = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        bus.echo = 1'b0;
    endtask

    // Runs the readings of one medir (caller already pulsed it) and returns
    // the number of edges between the last echo fall and pronto.
    task automatic runReadings(input int e0, input int e1, input int e2, input int e3,
                               input string tag, output int edges);
        int ns[4];
        ns = '{e0, e1, e2, e3};
        for (int i = 0; i < N_LEIT; i++) begin
            waitState(4'd2, {tag, "_espera"});
            applyStimulus(ns[i]);
        end
        edges = 0;
        while (bus.pronto !== 1'b1 && edges < 50) begin
            step();
            edges++;
        end
    endtask

    task automatic measureAndCheck(input int e0, input int e1, input int e2, input int e3,
                                   input string tag);
        int edges;
        int d;
        pulseMedir();
        checkOutput({tag, "_prontoLow"}, bus.pronto, 1'b0);
        runReadings(e0, e1, e2, e3, tag, edges);
        d = modelDist(e0, e1, e2, e3);
        checkOutput({tag, "_lat"}, edges, PRONTO_LAT);
        checkOutput({tag, "_dist"}, bus.distancia, d);
        checkOutput({tag, "_suf"}, bus.suficiente, d <= LIMIAR);
        expDist = d;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.medir = 1'b0;
        bus.zera = 1'b0;
        bus.echo = 1'b0;
        #3;
        checkOutput("rst_trigger", bus.trigger, 1'b0);
        checkOutput("rst_pronto", bus.pronto, 1'b0);
        checkOutput("rst_suf", bus.suficiente, 1'b0);
        checkOutput("rst_dist", bus.distancia, 0);
        checkOutput("rst_estado", bus.db_estado, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Trigger width, then the 80-clock echo (80/90/100/110 when averaging).
        checkOutput("trig_idle", bus.trigger, 1'b0);
        pulseMedir();
        checkOutput("trig_start", bus.trigger, 1'b1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.trigger === 1'b1) cnt++;
        end
        checkOutput("trig_width", cnt, TRIG);
        runReadings(80, 90, 100, 110, "suf80", lat);
        expDist = modelDist(80, 90, 100, 110);
        checkOutput("suf80_lat", lat, PRONTO_LAT);
        checkOutput("suf80_dist", bus.distancia, expDist);
        checkOutput("suf80_suf", bus.suficiente, expDist <= LIMIAR);

        measureAndCheck(109, 109, 109, 109, "b109");
        measureAndCheck(110, 110, 110, 110, "b110");

        for (int i = 0; i < 6; i++) begin
            int a, b, c, d;
            a = $urandom_range(1, 1500);
            b = $urandom_range(1, 1500);
            c = $urandom_range(1, 1500);
            d = $urandom_range(1, 1500);
            measureAndCheck(a, b, c, d, $sformatf("rand%0d", i));
        end
        measureAndCheck(50, 50, 50, 50, "d50");

        // No echo: abort after TMO clocks in espera_echo, results retained.
        pulseMedir();
        waitState(4'd2, "tmo_espera");
        cnt = 0;
        while (bus.db_estado !== 4'd0 && cnt < TMO + 100) begin
            step();
            cnt++;
        end
        checkOutput("tmo_cycles", cnt, TMO);
        checkOutput("tmo_estado", bus.db_estado, 0);
        checkOutput("tmo_pronto", bus.pronto, 1'b0);
        checkOutput("tmo_dist", bus.distancia, expDist);
        checkOutput("tmo_suf", bus.suficiente, expDist <= LIMIAR);

        // medir ignored while waiting; zera during mede_echo clears everything.
        pulseMedir();
        waitState(4'd2, "zera_espera");
        pulseMedir();
        checkOutput("medir_ignored", bus.db_estado, 4'd2);
        bus.echo = 1'b1;
        waitState(4'd3, "zera_mede");
        repeat (5) step();
        bus.zera = 1'b1;
        step();
        bus.zera = 1'b0;
        bus.echo = 1'b0;
        checkOutput("zera_estado", bus.db_estado, 0);
        checkOutput("zera_dist", bus.distancia, 0);
        checkOutput("zera_suf", bus.suficiente, 1'b0);

        bus.zera = 1'b1;
        bus.medir = 1'b1;
        step();
        bus.zera = 1'b0;
        bus.medir = 1'b0;
        checkOutput("zera_prio", bus.db_estado, 0);
        checkOutput("zera_prio_trig", bus.trigger, 1'b0);

        // Asynchronous reset while the trigger is high.
        pulseMedir();
        checkOutput("rstmid_trig_on", bus.trigger, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstmid_trig", bus.trigger, 1'b0);
        checkOutput("rstmid_estado", bus.db_estado, 0);
        step();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
